text_screen_ctrl: RTL and testbench

//  Sequences the on-screen text overlay for the Pong menu flow: title -> difficulty select -> play -> game over.

---
 rtl/pong_text_pkg.sv | 26 ++
 rtl/text_screen_ctrl_btn_edge.sv | 22 ++
 rtl/text_screen_ctrl.sv | 116 +++++++++++
 tb/tb_text_screen_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_text_pkg.sv
// Shared state codes, screen-ROM select codes and text-grid geometry for the Pong text overlay.
package pong_text_pkg;

   typedef enum logic [1:0] {ST_TITLE, ST_DIFF, ST_PLAY, ST_OVER} state_t;

   localparam logic [1:0] ROM_SEL_TITLE = 2'd0;
   localparam logic [1:0] ROM_SEL_EASY  = 2'd1;
   localparam logic [1:0] ROM_SEL_HARD  = 2'd2;
   localparam logic [1:0] ROM_SEL_OVER  = 2'd3;

   localparam int CHAR_W  = 8;
   localparam int CHAR_H  = 16;
   localparam int COLS    = 16;
   localparam int ROWS    = 2;
   localparam int LATENCY = 3;

   // Screen ROM shown for a menu state; PLAY blanks the overlay, so its code is never latched.
   function automatic logic [1:0] screen_sel(input state_t s, input logic diff);
      case (s)
         ST_DIFF: return diff ? ROM_SEL_HARD : ROM_SEL_EASY;
         ST_OVER: return ROM_SEL_OVER;
         default: return ROM_SEL_TITLE;
      endcase
   endfunction

endpackage

// File: rtl/text_screen_ctrl_btn_edge.sv
// Rising-edge pulse from a debounced button level; the pulse is registered one cycle after the rise.
module btn_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic prev;

   // prev tracks the level through reset so a button held across reset never fires.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev  <= level;
         pulse <= 1'b0;
      end else begin
         prev  <= level;
         pulse <= level & ~prev;
      end
   end

endmodule

// File: rtl/text_screen_ctrl.sv
// Menu-flow FSM, frame-latched screen select and 3-cycle text pixel pipeline for the Pong overlay.
module text_screen_ctrl
   import pong_text_pkg::*;
#(
   parameter logic [9:0] TEXT_X0 = 10'd256,
   parameter logic [9:0] TEXT_Y0 = 10'd224
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic        frame_start,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_start,
   input  logic        game_over,
   output logic [7:0]  char_xy,
   output logic [1:0]  rom_sel,
   input  logic [6:0]  char_code,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_word,
   output logic        text_on,
   output logic        difficulty,
   output logic        game_run
);

   localparam logic signed [10:0] WIN_W = 11'(COLS * CHAR_W);
   localparam logic signed [10:0] WIN_H = 11'(ROWS * CHAR_H);

   logic [2:0] btn_lvl, btn_pulse;
   logic       up_p, down_p, start_p;

   assign btn_lvl = {btn_start, btn_down, btn_up};
   assign {start_p, down_p, up_p} = btn_pulse;

   btn_edge_detect u_btn [2:0] (
      .clk   (clk),
      .reset (reset),
      .level (btn_lvl),
      .pulse (btn_pulse)
   );

   state_t state;
   logic   text_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_TITLE;
         difficulty <= 1'b0;
         game_run   <= 1'b0;
      end else begin
         case (state)
            ST_TITLE: if (start_p) state <= ST_DIFF;
            ST_DIFF: begin
               // start wins; simultaneous up+down cancel out
               if (start_p) begin
                  state    <= ST_PLAY;
                  game_run <= 1'b1;
               end else if (up_p && !down_p) begin
                  difficulty <= 1'b0;
               end else if (down_p && !up_p) begin
                  difficulty <= 1'b1;
               end
            end
            ST_PLAY: if (game_over) begin
               state    <= ST_OVER;
               game_run <= 1'b0;
            end
            ST_OVER: if (start_p) state <= ST_TITLE;
            default: state <= ST_TITLE;
         endcase
      end
   end

   // Screen select only moves at frame_start so a frame never shows two screens.
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_sel <= ROM_SEL_TITLE;
         text_en <= 1'b1;
      end else if (frame_start) begin
         text_en <= (state != ST_PLAY);
         if (state != ST_PLAY) rom_sel <= screen_sel(state, difficulty);
      end
   end

   logic signed [10:0] dx, dy;
   logic               in_win;
   logic [2:0]         bit_idx, bit_d1, bit_d2;

   assign dx      = $signed({1'b0, pixel_x}) - $signed({1'b0, TEXT_X0});
   assign dy      = $signed({1'b0, pixel_y}) - $signed({1'b0, TEXT_Y0});
   assign in_win  = video_on & text_en & (dx >= 11'sd0) & (dx < WIN_W) & (dy >= 11'sd0) & (dy < WIN_H);
   assign bit_idx = dx[2:0];
   assign char_xy = in_win ? {3'b000, dy[4], dx[6:3]} : 8'h00;

   logic [LATENCY-1:1] vld_pipe;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe  <= '0;
         font_addr <= '0;
         bit_d1    <= '0;
         bit_d2    <= '0;
         text_on   <= 1'b0;
      end else begin
         vld_pipe  <= {vld_pipe[LATENCY-2:1], in_win};
         font_addr <= {char_code, dy[3:0]};
         bit_d1    <= bit_idx;
         bit_d2    <= bit_d1;
         // bit 0 of the glyph column is the leftmost pixel, held in font_word[7]
         text_on   <= vld_pipe[LATENCY-1] & font_word[3'd7 - bit_d2];
      end
   end

endmodule

// File: tb/tb_text_screen_ctrl.sv
// Scoreboard bench for text_screen_ctrl: directed menu-flow scenarios, then randomized traffic vs a behavioural model.
module tb_text_screen_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  pixel_x = '0, pixel_y = '0;
   logic        video_on = 1'b0, frame_start = 1'b0;
   logic        btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0, game_over = 1'b0;
   logic [7:0]  char_xy;
   logic [1:0]  rom_sel;
   logic [6:0]  char_code;
   logic [10:0] font_addr;
   logic [7:0]  font_word = '0;
   logic        text_on, difficulty, game_run;
   bit          font_flat = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   text_screen_ctrl dut (
      .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .video_on(video_on), .frame_start(frame_start), .btn_up(btn_up),
      .btn_down(btn_down), .btn_start(btn_start), .game_over(game_over),
      .char_xy(char_xy), .rom_sel(rom_sel), .char_code(char_code),
      .font_addr(font_addr), .font_word(font_word), .text_on(text_on),
      .difficulty(difficulty), .game_run(game_run)
   );

   // Char ROMs: a distinct code per screen/row/col.
   function automatic logic [6:0] char_fn(input logic [1:0] sel, input logic row, input logic [3:0] col);
      return 7'((int'(sel) * 37 + int'(row) * 16 + int'(col) * 5 + 33) % 128);
   endfunction

   function automatic logic [7:0] font_fn(input logic [10:0] a);
      logic [31:0] h;
      if (font_flat) return 8'h80;
      h = {21'b0, a} * 32'h9E37_79B1;
      return h[23:16] ^ h[31:24];
   endfunction

   assign char_code = char_fn(rom_sel, char_xy[4], char_xy[3:0]);
   always @(posedge clk) font_word <= font_fn(font_addr);

   // ---------------- reference model ----------------
   typedef enum int {M_TITLE, M_DIFF, M_PLAY, M_OVER} mstate_t;
   typedef struct { bit t; bit [1:0] sel; bit run; bit diff; } exp_t;

   mstate_t m_state = M_TITLE;
   bit      m_diff = 0, m_run = 0, m_ten = 1;
   bit [1:0] m_sel = 0;
   bit [2:0] m_prev = 0, m_pulse = 0;   // {start, down, up}
   bit      p1 = 0, p2 = 0;
   exp_t    sbq[$];

   function automatic bit pixel_result(input int x, input int y, input bit vid, input bit ten, input bit [1:0] sel);
      int dx, dy;
      logic [6:0] ch;
      logic [7:0] w;
      dx = x - 256;
      dy = y - 224;
      if (!vid || !ten || dx < 0 || dx >= 128 || dy < 0 || dy >= 32) return 1'b0;
      ch = char_fn(sel, 1'(dy / 16), 4'(dx / 8));
      w  = font_fn({ch, 4'(dy % 16)});
      return w[7 - (dx % 8)];
   endfunction

   // Applies what one rising edge does, using the inputs presented during the preceding cycle.
   task automatic edge_model();
      bit res, out;
      mstate_t old_s;
      bit old_d;
      bit [2:0] lvl;
      exp_t e;
      lvl = {btn_start, btn_down, btn_up};
      res = pixel_result(int'(pixel_x), int'(pixel_y), video_on, m_ten, m_sel);
      if (reset) begin
         m_state = M_TITLE; m_diff = 0; m_run = 0; m_sel = 0; m_ten = 1;
         m_pulse = 0; m_prev = lvl; p1 = 0; p2 = 0; out = 0;
      end else begin
         old_s = m_state;
         old_d = m_diff;
         case (m_state)
            M_TITLE: if (m_pulse[2]) m_state = M_DIFF;
            M_DIFF:  if (m_pulse[2]) begin m_state = M_PLAY; m_run = 1; end
                     else if (m_pulse[1:0] == 2'b01) m_diff = 0;
                     else if (m_pulse[1:0] == 2'b10) m_diff = 1;
            M_PLAY:  if (game_over) begin m_state = M_OVER; m_run = 0; end
            M_OVER:  if (m_pulse[2]) m_state = M_TITLE;
         endcase
         if (frame_start) begin
            if (old_s == M_PLAY) m_ten = 0;
            else begin
               m_ten = 1;
               m_sel = (old_s == M_TITLE) ? 2'd0 : (old_s == M_OVER) ? 2'd3 : (old_d ? 2'd2 : 2'd1);
            end
         end
         out = p2; p2 = p1; p1 = res;
         m_pulse = lvl & ~m_prev;
         m_prev  = lvl;
      end
      e.t = out; e.sel = m_sel; e.run = m_run; e.diff = m_diff;
      sbq.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every clock the DUT presents a new output set; compare against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("sb_text_on",    int'(text_on),    int'(e.t));
         chk("sb_rom_sel",    int'(rom_sel),    int'(e.sel));
         chk("sb_game_run",   int'(game_run),   int'(e.run));
         chk("sb_difficulty", int'(difficulty), int'(e.diff));
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      edge_model();
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic frame_pulse();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
   endtask

   task automatic press(input int which);
      if (which == 0) btn_up = 1'b1; else if (which == 1) btn_down = 1'b1; else btn_start = 1'b1;
      tick();
      btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
      tick();
   endtask

   task automatic set_px(input int x, input int y, input bit vid);
      pixel_x = 10'(x); pixel_y = 10'(y); video_on = vid;
   endtask

   task automatic rand_win_px();
      set_px(256 + $urandom_range(0, 127), 224 + $urandom_range(0, 31), 1'b1);
   endtask

   initial begin
      ticks(2);
      chk("reset_font_addr", int'(font_addr), 0);
      chk("reset_text_on", int'(text_on), 0);
      reset = 1'b0;
      tick();

      // 1: title screen and window corners
      frame_pulse();
      chk("title_rom_sel", int'(rom_sel), 0);
      chk("title_game_run", int'(game_run), 0);
      set_px(256, 224, 1'b1); #1;
      chk("char_xy_origin", int'(char_xy), 8'h00);
      tick();
      set_px(383, 255, 1'b1); #1;
      chk("char_xy_corner", int'(char_xy), 8'h1F);
      tick();
      set_px(255, 224, 1'b1); #1;
      chk("char_xy_left_out", int'(char_xy), 8'h00);
      tick();
      set_px(0, 0, 1'b0);
      ticks(3);

      // 2: start then down; select waits for frame_start
      press(2);
      press(1);
      chk("diff_sel_before_frame", int'(rom_sel), 0);
      chk("diff_hard", int'(difficulty), 1);
      frame_pulse();
      chk("diff_sel_after_frame", int'(rom_sel), 2);

      // 3: up+down cancel, start+up goes to play
      btn_up = 1'b1; btn_down = 1'b1; tick();
      btn_up = 1'b0; btn_down = 1'b0; tick();
      chk("updown_cancel", int'(difficulty), 1);
      btn_start = 1'b1; btn_up = 1'b1; tick();
      btn_start = 1'b0; btn_up = 1'b0;
      chk("run_at_pulse", int'(game_run), 0);
      tick();
      chk("run_after_pulse", int'(game_run), 1);
      chk("startup_keep_diff", int'(difficulty), 1);

      // 4: play blanks the overlay, game_over leads to OVER screen
      frame_pulse();
      ticks(3);
      for (int i = 0; i < 40; i++) begin
         rand_win_px();
         tick();
         chk("play_blank", int'(text_on), 0);
      end
      set_px(0, 0, 1'b0);
      game_over = 1'b1; tick(); game_over = 1'b0;
      chk("over_run", int'(game_run), 0);
      frame_pulse();
      chk("over_rom_sel", int'(rom_sel), 3);

      // 5: pipeline latency with a flat 8'h80 font
      press(2);
      frame_pulse();
      chk("back_title_sel", int'(rom_sel), 0);
      chk("back_title_diff", int'(difficulty), 1);
      ticks(3);
      font_flat = 1'b1;
      ticks(3);
      set_px(256, 224, 1'b1); tick();
      set_px(257, 224, 1'b1); tick();
      chk("lat_pre", int'(text_on), 0);
      set_px(0, 0, 1'b0); tick();
      chk("lat_pixel_256", int'(text_on), 1);
      tick();
      chk("lat_pixel_257", int'(text_on), 0);
      ticks(3);
      font_flat = 1'b0;
      ticks(3);

      // 6: reset mid-PLAY with start held
      press(2);
      press(2);
      for (int i = 0; i < 6; i++) begin rand_win_px(); tick(); end
      set_px(300, 230, 1'b1);
      reset = 1'b1; btn_start = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_run", int'(game_run), 0);
      chk("rst_diff", int'(difficulty), 0);
      chk("rst_text_on_0", int'(text_on), 0);
      for (int i = 1; i < 3; i++) begin
         rand_win_px();
         tick();
         chk("rst_text_on_n", int'(text_on), 0);
      end
      ticks(4);
      btn_start = 1'b0;
      set_px(0, 0, 1'b0);
      tick();
      frame_pulse();
      chk("rst_held_start_no_pulse", int'(rom_sel), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         set_px($urandom_range(240, 400), $urandom_range(214, 262), $urandom_range(0, 9) != 0);
         frame_start = (i % 97 == 0);
         reset = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0: btn_up = ~btn_up;
               1: btn_down = ~btn_down;
               default: btn_start = ~btn_start;
            endcase
         end
         if ($urandom_range(0, 63) == 0) game_over = ~game_over;
         tick();
      end
      reset = 1'b0; frame_start = 1'b0;
      tick();
      @(negedge clk);
      #1;
      chk("sb_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
